// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit.
// Func codes, R-type marker, FSM states and decoded op class.
package muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MTHI  = 6'd17;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MTLO  = 6'd19;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_t;

  typedef struct packed {
    logic mfhi;
    logic mthi;
    logic mflo;
    logic mtlo;
    logic mul;
    logic div;
  } op_t;

endpackage

// File: rtl/muldiv_if.sv
// Pipeline <-> muldiv unit request/response bundle.
// master = pipeline side, slave = muldiv unit side.
interface muldiv_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       alu_op;
  logic [5:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, alu_op, func, a, b,
    input  busy, done, stall, result,
    input  hi, lo, div_zero
  );

  modport slave (
    input  start, alu_op, func, a, b,
    output busy, done, stall, result,
    output hi, lo, div_zero
  );

endinterface

// File: rtl/muldiv_decode.sv
// alu_op/func to one-hot op class plus signed flag.
// Purely combinational; also usable by ALU control.
module muldiv_decode
  import muldiv_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_func,
  output op_t        o_op,
  output logic       o_sgn
);

  always_comb begin
    o_op  = '0;
    o_sgn = 1'b0;
    if (i_alu_op == ALUOP_RTYPE) begin
      unique case (1'b1)
        (i_func == FN_MFHI):  o_op.mfhi = 1'b1;
        (i_func == FN_MTHI):  o_op.mthi = 1'b1;
        (i_func == FN_MFLO):  o_op.mflo = 1'b1;
        (i_func == FN_MTLO):  o_op.mtlo = 1'b1;
        (i_func == FN_MULT): begin
          o_op.mul = 1'b1;
          o_sgn    = 1'b1;
        end
        (i_func == FN_MULTU): o_op.mul = 1'b1;
        (i_func == FN_DIV): begin
          o_op.div = 1'b1;
          o_sgn    = 1'b1;
        end
        (i_func == FN_DIVU):  o_op.div = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or
// restoring shift-subtract step per cycle on magnitudes.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic   clk,
  input logic   rst_n,
  muldiv_if.slave bus
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_m;
  logic               r_isdiv;
  logic               r_qneg;
  logic               r_rneg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_zero;

  op_t                w_op;
  logic               w_sgn;
  logic               w_busy;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_sh;
  logic [WIDTH-1:0]   w_dif;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_pn;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fhi;
  logic [WIDTH-1:0]   w_flo;

  muldiv_decode u_dec (
    .i_alu_op (bus.alu_op),
    .i_func   (bus.func),
    .o_op     (w_op),
    .o_sgn    (w_sgn)
  );

  assign w_busy = (r_state != ST_IDLE);

  assign w_sa = w_sgn & bus.a[WIDTH-1];
  assign w_sb = w_sgn & bus.b[WIDTH-1];
  assign w_ma = w_sa ? -bus.a : bus.a;
  assign w_mb = w_sb ? -bus.b : bus.b;

  // multiply: {acc,q} shifts right, multiplicand added at top
  assign w_sum = {1'b0, r_acc}
               + (r_q[0] ? {1'b0, r_m} : '0);

  // divide: {acc,q} shifts left, quotient bits enter q[0]
  assign w_sh  = {r_acc, r_q[WIDTH-1]};
  assign w_ge  = (w_sh >= {1'b0, r_m});
  assign w_dif = w_sh[WIDTH-1:0] - r_m;

  assign w_prod = {r_acc, r_q};
  assign w_pn   = r_qneg ? -w_prod : w_prod;
  assign w_quo  = r_qneg ? -r_q : r_q;
  assign w_rem  = r_rneg ? -r_acc : r_acc;

  // x/0 leaves |a| in acc, so the remainder path yields a
  assign w_fhi = r_isdiv ? w_rem
                         : w_pn[2*WIDTH-1:WIDTH];
  assign w_flo = r_isdiv ? (r_div_zero ? '1 : w_quo)
                         : w_pn[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_m        <= '0;
      r_isdiv    <= 1'b0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            if (w_op.mthi) r_hi <= bus.a;
            if (w_op.mtlo) r_lo <= bus.a;
            if (w_op.mul || w_op.div) begin
              r_isdiv <= w_op.div;
              r_acc   <= '0;
              r_q     <= w_ma;
              r_m     <= w_mb;
              r_qneg  <= w_sa ^ w_sb;
              r_rneg  <= w_sa;
              r_cnt   <= CNT_W'(WIDTH);
              r_state <= ST_RUN;
              if (w_op.div)
                r_div_zero <= (bus.b == '0);
            end
          end
        end
        ST_RUN: begin
          if (r_isdiv) begin
            r_acc <= w_ge ? w_dif : w_sh[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          end
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1))
            r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_hi    <= w_fhi;
          r_lo    <= w_flo;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.stall    = bus.start & w_busy & (|w_op);
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.div_zero = r_div_zero;
  assign bus.result   = (bus.func == FN_MFHI) ? r_hi
                      : (bus.func == FN_MFLO) ? r_lo
                      : '0;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; legal values are 8 to 64.
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, giving the iteration counter width.
REQ-003 The block SHALL have ports as follows:
- clk, in, 1: single clock; all state updates on its rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: request qualifier for the current alu_op/func.
- alu_op, in, 2: 2'b10 marks R-type.
- func, in, 6: R-type function field.
- a, in, WIDTH: rs operand (multiplicand, dividend or mthi/mtlo source).
- b, in, WIDTH: rt operand (multiplier or divisor).
- busy, out, 1: an iterative operation is in progress.
- done, out, 1: one-cycle pulse; hi/lo were just updated by mult/div.
- stall, out, 1: the pipeline must hold the current instruction.
- result, out, WIDTH: mfhi/mflo read data.
- hi, out, WIDTH: HI register.
- lo, out, WIDTH: LO register.
- div_zero, out, 1: sticky flag for the last division, set when the divisor was 0.

Function
REQ-004 Decode SHALL be active only when alu_op==2'b10, with func mapped as: 16 mfhi, 17 mthi, 18 mflo, 19 mtlo, 24 mult, 25 multu, 26 div, 27 divu; every other func/alu_op is a no-op.
REQ-005 The FSM SHALL have states IDLE, RUN and FIX, and SHALL return to IDLE after FIX.
REQ-006 When start && decoded mult/multu/div/divu && IDLE at edge E0, the block SHALL latch operand magnitudes and sign flags, set count=WIDTH and enter RUN.
REQ-007 RUN SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle and SHALL decrement count, for exactly WIDTH cycles (edges E1..E_WIDTH).
REQ-008 FIX SHALL apply sign correction and write hi/lo at edge E_WIDTH+1.
REQ-009 done SHALL be high for the single cycle after E_WIDTH+1; total latency from acceptance to done is WIDTH+1 edges.
REQ-010 busy SHALL be high in RUN and FIX and low in IDLE, including the done cycle.
REQ-011 Multiply SHALL leave hi:lo holding the 2*WIDTH-bit product; mult is signed two's complement and multu is unsigned.
REQ-012 Divide SHALL leave lo as quotient and hi as remainder.
REQ-013 div SHALL truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-014 Divide by zero (b==0) SHALL still take full latency and give lo = all ones, hi = a, and SHALL set div_zero.
REQ-015 div_zero SHALL be cleared by the next accepted div/divu with nonzero b.
REQ-016 Signed overflow (a = most negative value, b = -1, div) SHALL give lo = a and hi = 0, with no flag raised.
REQ-017 mthi/mtlo with start in IDLE SHALL write a into hi/lo at the next edge, with zero latency from the pipeline view and no busy or done.
REQ-018 result SHALL be combinational: hi when func==mfhi, lo when func==mflo, 0 otherwise.
REQ-019 stall SHALL be combinational: start && busy && (any decoded muldiv op, mfhi, mflo, mthi or mtlo).
REQ-020 Any start that coincides with busy SHALL be ignored; the pipeline re-presents it after stall drops.
REQ-021 In the done cycle busy is low, so a new start SHALL be accepted back-to-back, and mfhi/mflo SHALL return the new values.
REQ-022 Operands a and b SHALL be don't-care after E0; changes to them SHALL not affect the running operation.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, and clear hi, lo, count, the internal accumulators, done and div_zero; busy and stall follow low.
REQ-024 Reset asserted mid-RUN or mid-FIX SHALL abort the operation with no done pulse and hi/lo = 0.
REQ-025 After rst_n deasserts, the first start SHALL be accepted at the first rising edge.

Structure
REQ-026 A shared package muldiv_pkg SHALL hold the func code constants (FN_MFHI=16, FN_MTHI=17, FN_MFLO=18, FN_MTLO=19, FN_MULT=24, FN_MULTU=25, FN_DIV=26, FN_DIVU=27), ALUOP_RTYPE=2'b10, and the state enum.
REQ-027 The block SHALL contain exactly one sub-module, muldiv_decode: combinational alu_op/func to one-hot op class plus signed flag, reusable by the ALU control.

Verification
REQ-028 With WIDTH=32, multu a=0xFFFFFFFF, b=0xFFFFFFFF: hi=0xFFFFFFFE and lo=0x00000001; done arrives exactly 33 edges after acceptance.
REQ-029 With WIDTH=32, mult a=-7, b=3: hi=0xFFFFFFFF and lo=0xFFFFFFEB; div a=-7, b=2: lo=0xFFFFFFFD (-3) and hi=0xFFFFFFFF (-1).
REQ-030 With WIDTH=32, divu a=100, b=0: lo=0xFFFFFFFF, hi=100 and div_zero=1; a following divu 100/7 gives lo=14, hi=2 and div_zero=0.
REQ-031 With WIDTH=32, div a=0x80000000, b=-1: lo=0x80000000 and hi=0; for WIDTH=8, mult 0x80*0x80 gives hi:lo=0x4000.
REQ-032 With WIDTH=32, mflo with start issued 5 cycles into a mult: stall=1 until the done cycle, and result then equals the new lo.
REQ-033 With WIDTH=32, rst_n pulsed low at RUN cycle 10: no done, busy=0, hi=lo=0, and the next mthi a=0x1234 gives hi=0x1234 one edge later.
